efuse_readout: RTL and testbench

- Capture stage directly downstream of the eFuse control state machine in read mode (mode = 2'b10).
- Monitors the CSB and SCLK strobes that the state machine drives into the eFuse macro, and deserialises the macro's serial output DOUT into a 32-bit word.
- Flags completion, compares the word against the programmed value, and reports truncated reads.
- Runs in the same divided-clock domain as the control state machine. SCLK and CSB are synchronous to clk, so no synchronisers are used.

---
 rtl/efuse_readout.sv | 141 ++++++++++++++
 tb/tb_efuse_readout.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_readout.sv
// eFuse read capture: watches CSB/SCLK from the control FSM, deserialises DOUT
// LSB-first on SCLK falling edges and reports completion, compare result and truncation.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for CSB to fall while the controller is in read mode
// CAPTURE  | shifting DOUT in on every SCLK falling edge
// DONE     | one cycle: publish the word, compare result and valid pulse
// WAIT_CSB | word published, ignore further SCLK until CSB returns high

module efuse_readout #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             CSB,
  input  logic             SCLK,
  input  logic             DOUT,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             match,
  output logic             busy,
  output logic             short_read
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [1:0] MODE_READ = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DONE     = 2'd2,
    WAIT_CSB = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             match_q, match_d;
  logic             short_read_q, short_read_d;
  logic             csb_prev_q, csb_prev_d;
  logic             sclk_prev_q, sclk_prev_d;

  logic csb_fall;
  logic csb_high;
  logic sclk_fall;

  assign csb_fall  = csb_prev_q & ~CSB;
  assign csb_high  = CSB;
  assign sclk_fall = sclk_prev_q & ~SCLK;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_reg_d  = shift_reg_q;
    data_out_d   = data_out_q;
    match_d      = match_q;
    data_valid_d = 1'b0;
    short_read_d = 1'b0;
    csb_prev_d   = CSB;
    sclk_prev_d  = SCLK;

    case (state_q)
      IDLE: begin
        if (csb_fall && (mode == MODE_READ)) begin
          state_d     = CAPTURE;
          bit_cnt_d   = '0;
          shift_reg_d = '0;
        end
      end

      CAPTURE: begin
        if (sclk_fall) begin
          shift_reg_d[bit_cnt_q[IW-1:0]] = DOUT;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        // A final bit landing together with CSB rising still counts as complete.
        if (sclk_fall && (bit_cnt_q == LAST_BIT)) begin
          state_d = DONE;
        end else if (csb_high) begin
          state_d      = IDLE;
          short_read_d = 1'b1;
          match_d      = 1'b0;
        end
      end

      DONE: begin
        data_out_d   = shift_reg_q;
        match_d      = (shift_reg_q == expected);
        data_valid_d = 1'b1;
        state_d      = WAIT_CSB;
      end

      WAIT_CSB: begin
        if (csb_high) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_reg_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      match_q      <= 1'b0;
      short_read_q <= 1'b0;
      // Idle strobe levels, so the first cycle after reset sees no edge.
      csb_prev_q   <= 1'b1;
      sclk_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_reg_q  <= shift_reg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      match_q      <= match_d;
      short_read_q <= short_read_d;
      csb_prev_q   <= csb_prev_d;
      sclk_prev_q  <= sclk_prev_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign match      = match_q;
  assign short_read = short_read_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_efuse_readout.sv
// Self-checking bench for efuse_readout: scoreboard of expected {match, word}
// pushed at stimulus time and compared against words captured on data_valid.

module tb_efuse_readout;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic             CSB;
  logic             SCLK;
  logic             DOUT;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             match;
  logic             busy;
  logic             short_read;

  int checks = 0;
  int failures = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] obs_q[$];
  int dv_cnt = 0;
  int sr_cnt = 0;
  int overlap_cnt = 0;

  efuse_readout #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .CSB        (CSB),
    .SCLK       (SCLK),
    .DOUT       (DOUT),
    .expected   (expected),
    .data_out   (data_out),
    .data_valid (data_valid),
    .match      (match),
    .busy       (busy),
    .short_read (short_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records every published word and pulse, away from the active edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_q.push_back({match, data_out});
      dv_cnt++;
    end
    if (short_read === 1'b1) sr_cnt++;
    if (data_valid === 1'b1 && short_read === 1'b1) overlap_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives CSB low then npulses SCLK pulses; returns just after the edge sampling the last bit.
  // Pulses beyond WIDTH carry inverted data so any extra capture would corrupt the word.
  task automatic run_read(input logic [WIDTH-1:0] word, input int npulses, input bit csb_with_last);
    CSB = 1'b0;
    tick();
    for (int i = 0; i < npulses; i++) begin
      SCLK = 1'b1;
      DOUT = (i < WIDTH) ? word[i] : ~word[i % WIDTH];
      tick();
      SCLK = 1'b0;
      if (csb_with_last && i == npulses - 1) CSB = 1'b1;
      tick();
    end
  endtask

  task automatic release_csb();
    CSB = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match: got %b want 0", match); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (short_read !== 1'b0) begin failures++; $display("FAIL reset_short_read: got %b want 0", short_read); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_read();
    logic [WIDTH:0] got, want;
    expected = 32'hA5C3_0F1E;
    mode = 2'b10;
    exp_q.push_back({1'b1, 32'hA5C3_0F1E});
    run_read(32'hA5C3_0F1E, 32, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL full_dv_early: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b want 1", busy); end
    tick();
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL full_dv_pulse: got %b want 1", data_valid); end
    checks++; if (data_out !== 32'hA5C3_0F1E) begin failures++; $display("FAIL full_data_out: got %h want a5c30f1e", data_out); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL full_match: got %b want 1", match); end
    tick();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL full_dv_width: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_wait: got %b want 1", busy); end
    CSB = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_drop: got %b want 0", busy); end
    tick();
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL full_scoreboard: got no word want %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("FAIL full_scoreboard: got %h want %h", got, want); end
    end
  endtask

  task automatic test_short_read();
    int dv0;
    dv0 = dv_cnt;
    run_read(32'h0000_03FF, 10, 1'b0);
    CSB = 1'b1;
    tick();
    checks++; if (short_read !== 1'b1) begin failures++; $display("FAIL short_pulse: got %b want 1", short_read); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy: got %b want 0", busy); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL short_match: got %b want 0", match); end
    checks++; if (data_out !== 32'hA5C3_0F1E) begin failures++; $display("FAIL short_data_hold: got %h want a5c30f1e", data_out); end
    tick();
    checks++; if (short_read !== 1'b0) begin failures++; $display("FAIL short_pulse_width: got %b want 0", short_read); end
    checks++; if (dv_cnt != dv0) begin failures++; $display("FAIL short_no_dv: got %0d pulses want 0", dv_cnt - dv0); end
  endtask

  task automatic test_mismatch();
    logic [WIDTH:0] got, want;
    expected = 32'hA5C3_0F1F;
    exp_q.push_back({1'b0, 32'hA5C3_0F1E});
    run_read(32'hA5C3_0F1E, 32, 1'b0);
    tick();
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL mism_dv: got %b want 1", data_valid); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL mism_match: got %b want 0", match); end
    release_csb();
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL mism_scoreboard: got no word want %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("FAIL mism_scoreboard: got %h want %h", got, want); end
    end
  endtask

  task automatic test_wrong_mode();
    int dv0;
    logic [WIDTH-1:0] prev;
    dv0 = dv_cnt;
    prev = data_out;
    mode = 2'b01;
    run_read(32'h1234_5678, 32, 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrong_mode_busy: got %b want 0", busy); end
    release_csb();
    tick();
    checks++; if (dv_cnt != dv0) begin failures++; $display("FAIL wrong_mode_dv: got %0d pulses want 0", dv_cnt - dv0); end
    checks++; if (data_out !== prev) begin failures++; $display("FAIL wrong_mode_data: got %h want %h", data_out, prev); end
    mode = 2'b10;
  endtask

  task automatic test_boundary();
    logic [WIDTH:0] got, want;
    int dv0, sr0;
    sr0 = sr_cnt;
    expected = 32'h1234_5678;
    exp_q.push_back({1'b1, 32'h1234_5678});
    run_read(32'h1234_5678, 32, 1'b1);
    tick();
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL edge_coincide_dv: got %b want 1", data_valid); end
    checks++; if (short_read !== 1'b0) begin failures++; $display("FAIL edge_coincide_sr: got %b want 0", short_read); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL edge_coincide_busy: got %b want 0", busy); end
    tick();
    checks++; if (sr_cnt != sr0) begin failures++; $display("FAIL edge_coincide_sr_cnt: got %0d want 0", sr_cnt - sr0); end
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL edge_coincide_sb: got no word want %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("FAIL edge_coincide_sb: got %h want %h", got, want); end
    end

    dv0 = dv_cnt;
    expected = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    run_read(32'hDEAD_BEEF, 40, 1'b0);
    release_csb();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL over40_busy: got %b want 0", busy); end
    checks++; if (dv_cnt - dv0 != 1) begin failures++; $display("FAIL over40_dv_count: got %0d want 1", dv_cnt - dv0); end
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL over40_sb: got no word want %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("FAIL over40_sb: got %h want %h", got, want); end
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [WIDTH:0] got, want;
    int dv0, sr0;
    dv0 = dv_cnt;
    sr0 = sr_cnt;
    run_read(32'hFFFF_FFFF, 16, 1'b0);
    rst = 1'b1;
    CSB = 1'b1;
    SCLK = 1'b0;
    tick();
    checks++; if (data_out !== '0) begin failures++; $display("FAIL rst_mid_data: got %h want 0", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL rst_mid_match: got %b want 0", match); end
    checks++; if (data_valid !== 1'b0 || short_read !== 1'b0) begin
      failures++; $display("FAIL rst_mid_pulses: got dv=%b sr=%b want 0 0", data_valid, short_read);
    end
    rst = 1'b0;
    tick();
    checks++; if (sr_cnt != sr0) begin failures++; $display("FAIL rst_mid_no_sr: got %0d want 0", sr_cnt - sr0); end
    expected = 32'h0000_0001;
    exp_q.push_back({1'b1, 32'h0000_0001});
    run_read(32'h0000_0001, 32, 1'b0);
    tick();
    checks++; if (data_out !== 32'h0000_0001) begin failures++; $display("FAIL rst_mid_reread: got %h want 00000001", data_out); end
    release_csb();
    checks++; if (dv_cnt - dv0 != 1) begin failures++; $display("FAIL rst_mid_dv_count: got %0d want 1", dv_cnt - dv0); end
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL rst_mid_sb: got no word want %h", exp_q[0]);
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin failures++; $display("FAIL rst_mid_sb: got %h want %h", got, want); end
    end
  endtask

  task automatic test_final();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL final_extra_words: got %0d want 0", obs_q.size()); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_missing_words: got %0d want 0", exp_q.size()); end
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL final_dv_sr_overlap: got %0d want 0", overlap_cnt); end
    checks++; if (sr_cnt != 1) begin failures++; $display("FAIL final_short_read_count: got %0d want 1", sr_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'b10;
    CSB = 1'b1;
    SCLK = 1'b0;
    DOUT = 1'b0;
    expected = '0;
    test_reset();
    test_full_read();
    test_short_read();
    test_mismatch();
    test_wrong_mode();
    test_boundary();
    test_reset_mid_capture();
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
